// File: rtl/hfc_pkg.sv
// hfc_pkg: shared types and constants for the hazard/forwarding controller.
// Rev 1.0
`default_nettype none

package hfc_pkg;

  localparam int         REG_W   = 5;
  localparam logic [1:0] MD_LOAD = 2'b01;

  typedef struct packed {
    logic             valid;
    logic             rw;
    logic [REG_W-1:0] da;
    logic             load;
  } sb_entry_t;

  // R0 is hardwired zero, so it can never carry a dependency.
  function automatic logic sb_match(input logic [REG_W-1:0] s, input sb_entry_t e);
    return e.valid & e.rw & (e.da == s) & (s != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hfc_scoreboard.sv
// hfc_scoreboard: 3-slot EX->MEM->WB destination tracker with bubble insert.
// Rev 1.0
`default_nettype none

module hfc_scoreboard
  import hfc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  sb_entry_t new_entry,
  output sb_entry_t ex,
  output sb_entry_t mem,
  output sb_entry_t wb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex  <= advance ? new_entry : '0;
      mem <= ex;
      wb  <= mem;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand hazard flags, load-use stall; optional stall counter (HFC_STALL_CNT_EN).
// Rev 1.0
`default_nettype none

module hazard_forward_ctrl
  import hfc_pkg::*;
#(
  parameter int REG_W = hfc_pkg::REG_W
`ifdef HFC_STALL_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_sa,
  input  logic [REG_W-1:0] id_sb,
  input  logic             id_ma,
  input  logic             id_mb,
  input  logic             id_rw,
  input  logic [REG_W-1:0] id_da,
  input  logic             id_load,
  input  logic             flush,
  output logic             ex_hazard_a,
  output logic             ex_hazard_b,
  output logic             wb_hazard_a,
  output logic             wb_hazard_b,
  output logic             stall
`ifdef HFC_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  sb_entry_t slot_ex, slot_mem, slot_wb, new_entry;
  logic      advance;
  logic      ex_a, ex_b, mem_a, mem_b;

  // The WB slot only completes the in-flight picture; nothing reads it here.
  logic [$bits(sb_entry_t):0] unused_slots;
  assign unused_slots = {slot_wb, slot_mem.load};

  assign ex_a  = ~id_ma & sb_match(id_sa, slot_ex);
  assign ex_b  = ~id_mb & sb_match(id_sb, slot_ex);
  assign mem_a = ~id_ma & sb_match(id_sa, slot_mem);
  assign mem_b = ~id_mb & sb_match(id_sb, slot_mem);

  assign stall   = id_valid & ~flush & slot_ex.load & (ex_a | ex_b);
  assign advance = id_valid & ~stall & ~flush;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.rw    = id_rw;
    new_entry.da    = id_da;
    new_entry.load  = id_load;
  end

  hfc_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .new_entry (new_entry),
    .ex        (slot_ex),
    .mem       (slot_mem),
    .wb        (slot_wb)
  );

  // Flags describe the instruction entering EX; a bubble carries none.
  always_ff @(posedge clk) begin
    if (rst || !advance) begin
      ex_hazard_a <= 1'b0;
      ex_hazard_b <= 1'b0;
      wb_hazard_a <= 1'b0;
      wb_hazard_b <= 1'b0;
    end else begin
      ex_hazard_a <= ex_a;
      ex_hazard_b <= ex_b;
      wb_hazard_a <= mem_a;
      wb_hazard_b <= mem_b;
    end
  end

`ifdef HFC_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: scoreboard-queue bench for hazard_forward_ctrl.
// Rev 1.0
`default_nettype none

module tb_hazard_forward_ctrl;
  import hfc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_ma, id_mb, id_rw, id_load, flush;
  logic [4:0] id_sa, id_sb, id_da;
  logic       ex_hazard_a, ex_hazard_b, wb_hazard_a, wb_hazard_b, stall;
`ifdef HFC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_sa       (id_sa),
    .id_sb       (id_sb),
    .id_ma       (id_ma),
    .id_mb       (id_mb),
    .id_rw       (id_rw),
    .id_da       (id_da),
    .id_load     (id_load),
    .flush       (flush),
    .ex_hazard_a (ex_hazard_a),
    .ex_hazard_b (ex_hazard_b),
    .wb_hazard_a (wb_hazard_a),
    .wb_hazard_b (wb_hazard_b),
    .stall       (stall)
`ifdef HFC_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares the instruction now in EX, then drives one decode cycle.
  // Flags are {ex_a, wb_a, ex_b, wb_b}; a stalled/flushed/empty slot expects none.
  task automatic step(input string tag, input logic v, input logic [4:0] sa, input logic [4:0] sb,
                      input logic ma, input logic mb, input logic rw, input logic [4:0] da,
                      input logic [1:0] md, input logic fl, input logic exp_stall,
                      input logic [3:0] exp_flags);
    @(negedge clk);
    if (exp_q.size() > 0)
      check({tag, ".ex_flags"}, {ex_hazard_a, wb_hazard_a, ex_hazard_b, wb_hazard_b}, exp_q.pop_front());
    id_valid = v; id_sa = sa; id_sb = sb; id_ma = ma; id_mb = mb;
    id_rw = rw; id_da = da; id_load = (md == MD_LOAD); flush = fl;
    #1;
    check({tag, ".stall"}, stall, exp_stall);
    if (exp_stall) exp_cnt++;
    exp_q.push_back((v && !fl && !exp_stall) ? exp_flags : 4'b0000);
  endtask

  task automatic nop(input string tag);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3; i++) nop(tag);
  endtask

  task automatic check_cnt(input string tag);
`ifdef HFC_STALL_CNT_EN
    check({tag, ".stall_cnt"}, {16'h0, stall_cnt}, exp_cnt);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    if (exp_q.size() > 0)
      check("pre_rst.ex_flags", {ex_hazard_a, wb_hazard_a, ex_hazard_b, wb_hazard_b}, exp_q.pop_front());
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    exp_q.push_back(4'b0000);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_sa = '0; id_sb = '0; id_ma = 1'b0; id_mb = 1'b0;
    id_rw = 1'b0; id_da = '0; id_load = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.flags", {ex_hazard_a, wb_hazard_a, ex_hazard_b, wb_hazard_b}, 4'b0000);
    check("reset.stall", stall, 1'b0);
    rst = 1'b0;
    check_cnt("reset");

    // ADD R3,R1,R2 ; SUB R4,R3,R5 -> forward from MEM
    step("add_sub.add", 1, 5'd1, 5'd2, 0, 0, 1, 5'd3, 2'b00, 0, 0, 4'b0000);
    step("add_sub.sub", 1, 5'd3, 5'd5, 0, 0, 1, 5'd4, 2'b00, 0, 0, 4'b1000);
    drain("add_sub");

    // ADD R3 ; NOP ; OR R6,R1,R3 -> B from WB
    step("add_nop_or.add", 1, 5'd1, 5'd2, 0, 0, 1, 5'd3, 2'b00, 0, 0, 4'b0000);
    nop("add_nop_or.nop");
    step("add_nop_or.or", 1, 5'd1, 5'd3, 0, 0, 1, 5'd6, 2'b00, 0, 0, 4'b0001);
    drain("add_nop_or");

    // LD R7 ; ADD R8,R7,R2 -> one stall then WB forward
    step("ld_use.ld", 1, 5'd1, 5'd0, 0, 1, 1, 5'd7, MD_LOAD, 0, 0, 4'b0000);
    step("ld_use.stall", 1, 5'd7, 5'd2, 0, 0, 1, 5'd8, 2'b00, 0, 1, 4'b0000);
    step("ld_use.go", 1, 5'd7, 5'd2, 0, 0, 1, 5'd8, 2'b00, 0, 0, 4'b0100);
    drain("ld_use");
    check_cnt("ld_use");

    // R0 writers never create hazards, load to R0 never stalls
    step("r0.wr", 1, 5'd1, 5'd2, 0, 0, 1, 5'd0, 2'b00, 0, 0, 4'b0000);
    step("r0.rd", 1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 2'b00, 0, 0, 4'b0000);
    step("r0.ld", 1, 5'd1, 5'd2, 0, 0, 1, 5'd0, MD_LOAD, 0, 0, 4'b0000);
    step("r0.rd2", 1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 2'b00, 0, 0, 4'b0000);
    drain("r0");

    // id_ma masks the A side
    step("ma.add", 1, 5'd1, 5'd2, 0, 0, 1, 5'd3, 2'b00, 0, 0, 4'b0000);
    step("ma.rd", 1, 5'd3, 5'd4, 1, 0, 1, 5'd9, 2'b00, 0, 0, 4'b0000);
    drain("ma");

    // Two writers of R3 -> both ex and wb on both operands
    step("dbl.add1", 1, 5'd1, 5'd2, 0, 0, 1, 5'd3, 2'b00, 0, 0, 4'b0000);
    step("dbl.add2", 1, 5'd1, 5'd2, 0, 0, 1, 5'd3, 2'b00, 0, 0, 4'b0000);
    step("dbl.rd", 1, 5'd3, 5'd3, 0, 0, 1, 5'd9, 2'b00, 0, 0, 4'b1111);
    drain("dbl");

    // Load-use masked by id_ma/id_mb -> no stall
    step("mask_ld.ld", 1, 5'd1, 5'd2, 0, 0, 1, 5'd9, MD_LOAD, 0, 0, 4'b0000);
    step("mask_ld.rd", 1, 5'd9, 5'd9, 1, 1, 1, 5'd10, 2'b00, 0, 0, 4'b0000);
    drain("mask_ld");

    // Flush during a would-be load-use stall, then reader sees load in MEM
    step("flush.ld", 1, 5'd1, 5'd2, 0, 0, 1, 5'd7, MD_LOAD, 0, 0, 4'b0000);
    step("flush.kill", 1, 5'd7, 5'd2, 0, 0, 1, 5'd8, 2'b00, 1, 0, 4'b0000);
    step("flush.next", 1, 5'd7, 5'd2, 0, 0, 1, 5'd8, 2'b00, 0, 0, 4'b0100);
    drain("flush");
    check_cnt("flush");

    // Reset with three writers in flight
    step("rst.w1", 1, 5'd1, 5'd2, 0, 0, 1, 5'd3, 2'b00, 0, 0, 4'b0000);
    step("rst.w2", 1, 5'd1, 5'd2, 0, 0, 1, 5'd4, 2'b00, 0, 0, 4'b0000);
    step("rst.w3", 1, 5'd1, 5'd2, 0, 0, 1, 5'd5, MD_LOAD, 0, 0, 4'b0000);
    do_reset();
    step("rst.rd1", 1, 5'd5, 5'd3, 0, 0, 1, 5'd9, 2'b00, 0, 0, 4'b0000);
    step("rst.rd2", 1, 5'd4, 5'd3, 0, 0, 1, 5'd9, 2'b00, 0, 0, 4'b0000);
    drain("rst");
    check_cnt("rst");

    nop("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
